// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-ported, fixed-latency memory between
// the fetch stage and the memory stage. One access is in flight at a time:
// IDLE (arbitrate, latch) -> ISSUE (command strobe) -> WAIT (MEM_LAT cycles)
// -> RESP (ready pulse) -> IDLE.
//
// Handshake: a requester raises req with stable addr/we/wdata and holds it
// until its ready pulses. ready is a one-cycle completion strobe, not
// backpressure. req still high in the cycle after ready is a new request.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate the winner on
// contention. Otherwise the data side wins contention, with a starvation
// guard that forces a fetch grant after STARVE_MAX consecutive losses.
//
// dbg_state exposes the FSM state; dbg_starve_cnt exposes the starvation
// counter (constant 0 in the round-robin build). STARVE_MAX must fit 8 bits.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m,
  output logic [1:0]        dbg_state,
  output logic [7:0]        dbg_starve_cnt
);

  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               owner_dm;
  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [CNT_W-1:0]   lat_cnt;
  logic               any_req;
  logic               grant_dm;

  assign any_req = if_req | dm_req;

`ifdef ARB_ROUND_ROBIN_EN
  // last_dm = 0 means fetch was granted last, so data wins the first contention
  logic last_dm;

  // Winner selection: alternate on contention, otherwise whoever asks
  assign grant_dm       = dm_req & (~if_req | ~last_dm);
  assign dbg_starve_cnt = 8'd0;

  // Remember the side granted at each IDLE decision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_dm <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_dm <= grant_dm;
    end
  end
`else
  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;
  logic          starved;

  // Winner selection: data priority unless fetch has lost STARVE_MAX times
  assign starved        = (starve_cnt == SW'(STARVE_MAX));
  assign grant_dm       = dm_req & ~(if_req & starved);
  assign dbg_starve_cnt = 8'(starve_cnt);

  // Count fetch losses at IDLE decisions; clear on any fetch grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE && any_req) begin
      if (!grant_dm) begin
        starve_cnt <= '0;
      end else if (if_req && !starved) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: one access per MEM_LAT+3 cycles, no back-to-back issue
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (lat_cnt == CNT_W'(1)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, latency counter and per-requester read-data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_dm  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_cnt   <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_dm  <= grant_dm;
            lat_we    <= grant_dm & dm_we;
            lat_addr  <= grant_dm ? dm_addr : if_addr;
            lat_wdata <= grant_dm ? dm_wdata : '0;
          end
        end
        ISSUE: lat_cnt <= CNT_W'(MEM_LAT);
        WAIT: begin
          lat_cnt <= lat_cnt - CNT_W'(1);
          // The last WAIT cycle is issue+MEM_LAT: memory data is valid now
          if (lat_cnt == CNT_W'(1)) begin
            if (owner_dm) dm_rdata <= mem_rdata;
            else          if_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Command bus is zero whenever no command is being strobed
  always_comb begin
    mem_en    = (state == ISSUE);
    mem_we    = mem_en & lat_we;
    mem_addr  = mem_en ? lat_addr  : '0;
    mem_wdata = mem_en ? lat_wdata : '0;
  end

  // Ready pulses and hazard stalls; stalls are forced low while in reset
  always_comb begin
    if_ready  = (state == RESP) & ~owner_dm;
    dm_ready  = (state == RESP) &  owner_dm;
    stall_f   = rst & if_req & ~if_ready;
    stall_m   = rst & dm_req & ~dm_ready;
    dbg_state = state;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter (default build, MEM_LAT=2, STARVE_MAX=4).
module tb_unified_mem_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic        if_ready, dm_ready, mem_en, mem_we, stall_f, stall_m;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_starve_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory environment ----------------
  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] pipe [MEM_LAT];

  // Command seen in cycle t returns data in cycle t+MEM_LAT; otherwise noise
  initial begin
    logic        c_en, c_we;
    logic [31:0] c_addr, c_wd;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'h1000_0000 + 32'(i * 7);
      ref_mem[i] = env_mem[i];
    end
    for (int i = 0; i < MEM_LAT; i++) pipe[i] = '0;
    forever begin
      @(negedge clk);
      c_en = mem_en; c_we = mem_we; c_addr = mem_addr; c_wd = mem_wdata;
      @(posedge clk);
      #1;
      for (int i = MEM_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = (c_en && !c_we) ? env_mem[c_addr[9:2]] : $urandom;
      if (c_en && c_we) env_mem[c_addr[9:2]] = c_wd;
      mem_rdata = pipe[MEM_LAT-1];
    end
  end

  task automatic poke(input logic [31:0] addr, input logic [31:0] val);
    env_mem[addr[9:2]] = val;
    ref_mem[addr[9:2]] = val;
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Transaction level: a decision in an idle cycle c owns the memory until
  // c+MEM_LAT+3; command at c+1, ready at c+MEM_LAT+2.
  bit          mon_en = 0;
  int          p_issue = -1, p_ready = -1, free_at = 0, starve = 0;
  logic        p_dm = 0, p_we = 0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic [31:0] exp_q [$];
  logic [31:0] if_last = '0, dm_last = '0;
  bit          dm_known = 1;

  task automatic model_reset();
    p_issue = -1; p_ready = -1; free_at = 0; starve = 0;
    exp_q.delete();
    if_last = '0; dm_last = '0; dm_known = 1;
  endtask

  initial begin
    logic        e_en, e_if, e_dm, win_dm;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        e_en = (cyc == p_issue);
        e_if = (cyc == p_ready) && !p_dm;
        e_dm = (cyc == p_ready) &&  p_dm;
        check("mem_en", mem_en, e_en);
        check("mem_we", mem_we, e_en ? p_we : 1'b0);
        check("mem_addr", mem_addr, e_en ? p_addr : 32'h0);
        if (!e_en || p_we) check("mem_wdata", mem_wdata, e_en ? p_wdata : 32'h0);
        check("if_ready", if_ready, e_if);
        check("dm_ready", dm_ready, e_dm);
        check("stall_f", stall_f, if_req & ~e_if);
        check("stall_m", stall_m, dm_req & ~e_dm);
        check("starve_cnt", dbg_starve_cnt, starve);
        if (e_if || e_dm) begin
          d = exp_q.pop_front();
          if (e_if)      if_last = d;
          else if (p_we) dm_known = 0;
          else begin dm_last = d; dm_known = 1; end
        end
        check("if_rdata", if_rdata, if_last);
        if (dm_known) check("dm_rdata", dm_rdata, dm_last);
        if (cyc >= free_at && (if_req || dm_req)) begin
          win_dm = dm_req && !(if_req && starve == STARVE_MAX);
          if (!win_dm) starve = 0;
          else if (if_req && starve < STARVE_MAX) starve++;
          p_dm    = win_dm;
          p_we    = win_dm & dm_we;
          p_addr  = win_dm ? dm_addr : if_addr;
          p_wdata = win_dm ? dm_wdata : 32'h0;
          exp_q.push_back(p_we ? 32'h0 : ref_mem[p_addr[9:2]]);
          if (p_we) ref_mem[p_addr[9:2]] = p_wdata;
          p_issue = cyc + 1;
          p_ready = cyc + MEM_LAT + 2;
          free_at = cyc + MEM_LAT + 3;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre;
    logic [31:0] pre_val;
    logic        chk;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v, input int idx);
    logic rdy, stl;
    logic [31:0] rd;
    if (v.pre) poke(v.addr, v.pre_val);
    @(posedge clk); #1;
    if (v.is_dm) begin dm_req = 1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; end
    else begin if_req = 1; if_addr = v.addr; end
    for (int k = 0; k <= MEM_LAT + 3; k++) begin
      @(negedge clk);
      check($sformatf("v%0d_mem_en_k%0d", idx, k), mem_en, k == 1);
      if (k == 1) begin
        check($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
        check($sformatf("v%0d_mem_we", idx), mem_we, v.we);
        if (v.we) check($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.wdata);
      end
      rdy = v.is_dm ? dm_ready : if_ready;
      stl = v.is_dm ? stall_m : stall_f;
      rd  = v.is_dm ? dm_rdata : if_rdata;
      check($sformatf("v%0d_ready_k%0d", idx, k), rdy, k == MEM_LAT + 2);
      check($sformatf("v%0d_stall_k%0d", idx, k), stl, k < MEM_LAT + 2);
      if (v.chk && k >= MEM_LAT + 2) check($sformatf("v%0d_rdata_k%0d", idx, k), rd, v.exp_rdata);
      if (k == MEM_LAT + 2) begin
        @(posedge clk); #1;
        if (v.is_dm) dm_req = 0; else if_req = 0;
      end
    end
  endtask

  // Drop each request after its ready; bounded
  task automatic finish_reqs();
    logic r_if, r_dm;
    for (int c = 0; c < 60 && (if_req || dm_req); c++) begin
      @(negedge clk);
      r_if = if_ready; r_dm = dm_ready;
      @(posedge clk); #1;
      if (r_if) if_req = 0;
      if (r_dm) dm_req = 0;
    end
    check("drain_done", {if_req, dm_req}, 2'b00);
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic        r_if, r_dm;
    bit          grant_q [$];
    bit          exp_grants [6];

    vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,    1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h40,  32'h1234, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h40,  32'h0,    1'b0, 32'h0,        1'b1, 32'h1234};
    vecs[3] = '{1'b0, 1'b0, 32'h40,  32'h0,    1'b0, 32'h0,        1'b1, 32'h1234};
    vecs[4] = '{1'b1, 1'b0, 32'h3FC, 32'hCAFE, 1'b1, 32'hA5A55A5A, 1'b1, 32'hA5A55A5A};
    vecs[5] = '{1'b0, 1'b0, 32'h0,   32'h0,    1'b1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF};
    exp_grants = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset held with both requests high
    if_req = 1; if_addr = 32'h50; dm_req = 1; dm_we = 0; dm_addr = 32'h60;
    repeat (3) begin
      @(negedge clk);
      check("rst_mem_en", mem_en, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_ready", {if_ready, dm_ready}, 2'b00);
      check("rst_stall", {stall_f, stall_m}, 2'b00);
      check("rst_rdata", if_rdata | dm_rdata, 32'h0);
      check("rst_state", dbg_state, 2'd0);
    end
    @(posedge clk); #1;
    model_reset(); mon_en = 1; rst = 1;
    @(negedge clk);
    check("post_rst_idle_no_en", mem_en, 1'b0);
    @(negedge clk);
    check("post_rst_first_en", mem_en, 1'b1);
    check("post_rst_first_addr", mem_addr, 32'h60);
    finish_reqs();

    // Table-driven single accesses
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Contention: data first, fetch granted in the IDLE right after
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h20; dm_req = 1; dm_we = 0; dm_addr = 32'h30;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("cont_mem_en_k%0d", k), mem_en, (k == 1) || (k == 6));
      if (k == 1) check("cont_addr_dm", mem_addr, 32'h30);
      if (k == 6) check("cont_addr_if", mem_addr, 32'h20);
      check($sformatf("cont_dm_ready_k%0d", k), dm_ready, k == 4);
      check($sformatf("cont_if_ready_k%0d", k), if_ready, k == 9);
      if (k == 4) begin @(posedge clk); #1; dm_req = 0; end
      if (k == 9) begin @(posedge clk); #1; if_req = 0; end
    end

    // Starvation: both held; fetch forced through after STARVE_MAX losses
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h90; dm_req = 1; dm_we = 0; dm_addr = 32'h80;
    for (int c = 0; c < 80 && grant_q.size() < 6; c++) begin
      @(negedge clk);
      if (mem_en) grant_q.push_back(mem_addr == 32'h80);
      r_if = if_ready;
      @(posedge clk); #1;
      if (r_if) if_req = 0;
    end
    check("starve_grant_count", grant_q.size(), 6);
    for (int i = 0; i < 6 && i < grant_q.size(); i++)
      check($sformatf("starve_grant%0d_is_dm", i), grant_q[i], exp_grants[i]);
    finish_reqs();
    check("starve_cnt_cleared", dbg_starve_cnt, 8'd0);

    // Reset in WAIT: no ready for the aborted access, restart in IDLE
    @(posedge clk); #1;
    dm_req = 1; dm_we = 0; dm_addr = 32'h44;
    @(negedge clk);
    @(negedge clk);
    check("wrst_issue", mem_en, 1'b1);
    @(posedge clk); #1;
    check("wrst_in_wait", dbg_state, 2'd2);
    mon_en = 0;
    #2 rst = 0;
    #1;
    check("wrst_async_state", dbg_state, 2'd0);
    check("wrst_async_ready", dm_ready, 1'b0);
    check("wrst_async_stall", stall_m, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("wrst_hold_en", mem_en, 1'b0);
      check("wrst_hold_ready", {if_ready, dm_ready}, 2'b00);
    end
    @(posedge clk); #1;
    dm_req = 0; model_reset(); rst = 1; mon_en = 1;
    repeat (6) begin
      @(negedge clk);
      check("wrst_no_ready", dm_ready, 1'b0);
      check("wrst_idle", dbg_state, 2'd0);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      r_if = if_ready; r_dm = dm_ready;
      @(posedge clk); #1;
      if (if_req) begin
        if (r_if) begin
          if ($urandom_range(0, 1) == 1) if_addr = rand_addr();
          else if_req = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = rand_addr();
      end
      if (dm_req) begin
        if (r_dm) begin
          if ($urandom_range(0, 1) == 1) begin
            dm_addr = rand_addr(); dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
          end else dm_req = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        dm_req = 1; dm_addr = rand_addr(); dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
      end
    end
    finish_reqs();
    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
